pipeline_hazard_ctrl: RTL and testbench

//   Stage-control sequencer for the 5-stage MIPS pipeline datapath. Generates the per-stage
//   rst/en strobes, ID-stage forwarding selects and store-data forward (fwd_m). FSM covers

---
 rtl/pipeline_hazard_ctrl_if.sv | 42 ++++
 rtl/pipeline_hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus between the 5-stage datapath (master) and the stage-control
// sequencer (slave): ID/EXE/MEM hazard information in, stage strobes and forward selects out.
interface pipeline_hazard_ctrl_if;
   logic [4:0] addr_rs;
   logic [4:0] addr_rt;
   logic       rs_used;
   logic       rt_used;
   logic       is_store_id;
   logic       is_branch_id;
   logic       id_valid;
   logic [4:0] regw_addr_exe;
   logic [4:0] regw_addr_mem;
   logic       wb_wen_exe;
   logic       wb_wen_mem;
   logic       wb_data_src_exe;
   logic       wb_data_src_mem;
   logic       mem_req;
   logic       mem_ready;
   logic       if_rst, id_rst, exe_rst, mem_rst, wb_rst;
   logic       if_en, id_en, exe_en, mem_en, wb_en;
   logic [1:0] exe_fwd_a_ctrl;
   logic [1:0] exe_fwd_b_ctrl;
   logic       fwd_m;

   modport master (
      output addr_rs, addr_rt, rs_used, rt_used, is_store_id, is_branch_id, id_valid,
             regw_addr_exe, regw_addr_mem, wb_wen_exe, wb_wen_mem,
             wb_data_src_exe, wb_data_src_mem, mem_req, mem_ready,
      input  if_rst, id_rst, exe_rst, mem_rst, wb_rst,
             if_en, id_en, exe_en, mem_en, wb_en,
             exe_fwd_a_ctrl, exe_fwd_b_ctrl, fwd_m
   );

   modport slave (
      input  addr_rs, addr_rt, rs_used, rt_used, is_store_id, is_branch_id, id_valid,
             regw_addr_exe, regw_addr_mem, wb_wen_exe, wb_wen_mem,
             wb_data_src_exe, wb_data_src_mem, mem_req, mem_ready,
      output if_rst, id_rst, exe_rst, mem_rst, wb_rst,
             if_en, id_en, exe_en, mem_en, wb_en,
             exe_fwd_a_ctrl, exe_fwd_b_ctrl, fwd_m
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stage-control sequencer for the 5-stage MIPS pipeline: reset sequencing, load-use stalls,
// branch fetch suppression, memory-wait freezes, operand forwarding and perf counters.
module pipeline_hazard_ctrl #(
   parameter int RST_CYCLES = 2,
   parameter int CNT_W      = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pipeline_hazard_ctrl_if.slave hz,
   output logic [CNT_W-1:0]     stall_cycles,
   output logic [CNT_W-1:0]     flush_count
);

   typedef enum logic [2:0] {RESET_SEQ, RUN, LOAD_STALL, BRANCH_WAIT, MEM_WAIT} state_t;

   localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RW-1:0] RST_INIT = RW'(RST_CYCLES - 1);

   localparam logic [1:0] FWD_NO      = 2'd0;
   localparam logic [1:0] FWD_ALU_EXE = 2'd1;
   localparam logic [1:0] FWD_ALU_MEM = 2'd2;
   localparam logic [1:0] FWD_MEM     = 2'd3;

   state_t          state, state_nx, held, held_nx, eff;
   logic [RW-1:0]   cnt, cnt_nx;
   logic            br_phase, br_phase_nx;
   logic            exe_load, rs_load, rt_load_match, load_use, store_fwd;
   logic            mem_wait, branch_take, count_flush;

   // A load in EXE whose destination equals the operand's register must not be forwarded from EXE.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] a, input logic used,
      input logic [4:0] de, input logic we, input logic le,
      input logic [4:0] dm, input logic wm, input logic lm);
      fwd_sel = FWD_NO;
      if (used && a != 5'd0) begin
         if (we && a == de)      fwd_sel = le ? FWD_NO : FWD_ALU_EXE;
         else if (wm && a == dm) fwd_sel = lm ? FWD_MEM : FWD_ALU_MEM;
      end
   endfunction

   always_comb begin
      exe_load      = hz.wb_wen_exe & hz.wb_data_src_exe & (hz.regw_addr_exe != 5'd0);
      rs_load       = exe_load & hz.rs_used & (hz.addr_rs == hz.regw_addr_exe);
      rt_load_match = exe_load & (hz.addr_rt == hz.regw_addr_exe);
      load_use      = rs_load | (rt_load_match & hz.rt_used & ~hz.is_store_id);
      store_fwd     = hz.is_store_id & rt_load_match & ~rs_load;
      mem_wait      = hz.mem_req & ~hz.mem_ready;
      branch_take   = hz.id_valid & hz.is_branch_id;
      eff           = (state == MEM_WAIT) ? held : state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RESET_SEQ;
         held     <= RUN;
         cnt      <= RST_INIT;
         br_phase <= 1'b0;
      end else begin
         state    <= state_nx;
         held     <= held_nx;
         cnt      <= cnt_nx;
         br_phase <= br_phase_nx;
      end
   end

   // MEM_WAIT remembers the interrupted state so a branch countdown resumes where it stopped.
   always_comb begin
      state_nx    = state;
      held_nx     = held;
      cnt_nx      = cnt;
      br_phase_nx = br_phase;
      if (state == RESET_SEQ) begin
         if (cnt == '0) state_nx = RUN;
         else           cnt_nx   = cnt - RW'(1);
      end else if (mem_wait) begin
         state_nx = MEM_WAIT;
         held_nx  = eff;
      end else begin
         case (eff)
            BRANCH_WAIT: begin
               state_nx    = br_phase ? RUN : BRANCH_WAIT;
               br_phase_nx = ~br_phase;
            end
            default: begin
               if (load_use) begin
                  state_nx = LOAD_STALL;
               end else if (branch_take) begin
                  state_nx    = BRANCH_WAIT;
                  br_phase_nx = 1'b0;
               end else begin
                  state_nx = RUN;
               end
            end
         endcase
      end
   end

   always_comb begin
      hz.if_rst  = 1'b0;
      hz.id_rst  = 1'b0;
      hz.exe_rst = 1'b0;
      hz.mem_rst = 1'b0;
      hz.wb_rst  = 1'b0;
      hz.if_en   = 1'b1;
      hz.id_en   = 1'b1;
      hz.exe_en  = 1'b1;
      hz.mem_en  = 1'b1;
      hz.wb_en   = 1'b1;
      hz.exe_fwd_a_ctrl = fwd_sel(hz.addr_rs, hz.rs_used, hz.regw_addr_exe, hz.wb_wen_exe,
                                  hz.wb_data_src_exe, hz.regw_addr_mem, hz.wb_wen_mem,
                                  hz.wb_data_src_mem);
      hz.exe_fwd_b_ctrl = fwd_sel(hz.addr_rt, hz.rt_used, hz.regw_addr_exe, hz.wb_wen_exe,
                                  hz.wb_data_src_exe, hz.regw_addr_mem, hz.wb_wen_mem,
                                  hz.wb_data_src_mem);
      hz.fwd_m    = store_fwd;
      count_flush = 1'b0;
      if (state == RESET_SEQ) begin
         {hz.if_rst, hz.id_rst, hz.exe_rst, hz.mem_rst, hz.wb_rst} = 5'b11111;
         {hz.if_en, hz.id_en, hz.exe_en, hz.mem_en, hz.wb_en}      = 5'b00000;
         hz.exe_fwd_a_ctrl = FWD_NO;
         hz.exe_fwd_b_ctrl = FWD_NO;
         hz.fwd_m          = 1'b0;
      end else if (mem_wait) begin
         {hz.if_en, hz.id_en, hz.exe_en, hz.mem_en} = 4'b0000;
         hz.wb_rst = 1'b1;
      end else begin
         case (eff)
            BRANCH_WAIT: begin
               hz.id_rst = 1'b1;
               hz.if_en  = br_phase;
            end
            default: begin
               if (load_use) begin
                  hz.if_en   = 1'b0;
                  hz.id_en   = 1'b0;
                  hz.exe_rst = 1'b1;
               end else if (branch_take) begin
                  hz.if_en    = 1'b0;
                  hz.id_rst   = 1'b1;
                  count_flush = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (state != RESET_SEQ && !hz.if_en && stall_cycles != '1)
            stall_cycles <= stall_cycles + CNT_W'(1);
         if (count_flush && flush_count != '1)
            flush_count <= flush_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: reset sequencing, load-use, forwarding,
// store-data forward, branch suppression and memory-wait freeze with hand-computed values.
module tb_pipeline_hazard_ctrl;

   logic        clk;
   logic        rst_n;
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;
   int          n_asserts;
   int          n_fail;

   pipeline_hazard_ctrl_if hz_bus ();

   pipeline_hazard_ctrl #(.RST_CYCLES(2), .CNT_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .hz           (hz_bus.slave),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives a full ID/EXE/MEM picture with memory idle, then lets the comb outputs settle.
   task automatic applyStimulus(
      input logic [4:0] rs, input logic [4:0] rt, input logic rs_u, input logic rt_u,
      input logic store, input logic branch,
      input logic [4:0] de, input logic we, input logic le,
      input logic [4:0] dm, input logic wm, input logic lm);
      hz_bus.addr_rs         = rs;
      hz_bus.addr_rt         = rt;
      hz_bus.rs_used         = rs_u;
      hz_bus.rt_used         = rt_u;
      hz_bus.is_store_id     = store;
      hz_bus.is_branch_id    = branch;
      hz_bus.id_valid        = 1'b1;
      hz_bus.regw_addr_exe   = de;
      hz_bus.wb_wen_exe      = we;
      hz_bus.wb_data_src_exe = le;
      hz_bus.regw_addr_mem   = dm;
      hz_bus.wb_wen_mem      = wm;
      hz_bus.wb_data_src_mem = lm;
      hz_bus.mem_req         = 1'b0;
      hz_bus.mem_ready       = 1'b1;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rst_vec();
      return {27'd0, hz_bus.if_rst, hz_bus.id_rst, hz_bus.exe_rst, hz_bus.mem_rst, hz_bus.wb_rst};
   endfunction

   function automatic logic [31:0] en_vec();
      return {27'd0, hz_bus.if_en, hz_bus.id_en, hz_bus.exe_en, hz_bus.mem_en, hz_bus.wb_en};
   endfunction

   initial begin
      n_asserts = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      applyStimulus(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_rst_vec", rst_vec(), 32'h1f);
      checkOutput("reset_en_vec", en_vec(), 32'h00);
      checkOutput("reset_stall_cnt", stall_cycles, 32'd0);
      checkOutput("reset_flush_cnt", flush_count, 32'd0);

      rst_n = 1'b1;
      #1;
      checkOutput("rstseq0_rst_vec", rst_vec(), 32'h1f);
      tick();
      checkOutput("rstseq1_rst_vec", rst_vec(), 32'h1f);
      checkOutput("rstseq1_en_vec", en_vec(), 32'h00);
      tick();
      checkOutput("run_rst_vec", rst_vec(), 32'h00);
      checkOutput("run_en_vec", en_vec(), 32'h1f);

      // lw $8 in EXE, add rs=$8 in ID
      applyStimulus(5'd8, 5'd3, 1, 1, 0, 0, 5'd8, 1, 1, 5'd0, 0, 0);
      checkOutput("ldu_rst_vec", rst_vec(), 32'h04);
      checkOutput("ldu_en_vec", en_vec(), 32'h07);
      tick();
      applyStimulus(5'd8, 5'd3, 1, 1, 0, 0, 5'd0, 0, 0, 5'd8, 1, 1);
      checkOutput("ldu_retry_fwd_a", {30'd0, hz_bus.exe_fwd_a_ctrl}, 32'd3);
      checkOutput("ldu_retry_fwd_b", {30'd0, hz_bus.exe_fwd_b_ctrl}, 32'd0);
      checkOutput("ldu_retry_en_vec", en_vec(), 32'h1f);
      checkOutput("ldu_retry_rst_vec", rst_vec(), 32'h00);
      checkOutput("ldu_stall_cnt", stall_cycles, 32'd1);
      tick();

      // add $9 in EXE (MEM also writes $9: EXE must win), sub rs=$9 rt=$9
      applyStimulus(5'd9, 5'd9, 1, 1, 0, 0, 5'd9, 1, 0, 5'd9, 1, 1);
      checkOutput("alu_exe_fwd_a", {30'd0, hz_bus.exe_fwd_a_ctrl}, 32'd1);
      checkOutput("alu_exe_fwd_b", {30'd0, hz_bus.exe_fwd_b_ctrl}, 32'd1);
      checkOutput("alu_exe_en_vec", en_vec(), 32'h1f);
      applyStimulus(5'd0, 5'd0, 1, 1, 0, 0, 5'd0, 1, 0, 5'd9, 1, 0);
      checkOutput("reg0_fwd_a", {30'd0, hz_bus.exe_fwd_a_ctrl}, 32'd0);
      checkOutput("reg0_fwd_b", {30'd0, hz_bus.exe_fwd_b_ctrl}, 32'd0);
      applyStimulus(5'd9, 5'd7, 1, 1, 0, 0, 5'd5, 1, 0, 5'd9, 1, 0);
      checkOutput("alu_mem_fwd_a", {30'd0, hz_bus.exe_fwd_a_ctrl}, 32'd2);
      checkOutput("nomatch_fwd_b", {30'd0, hz_bus.exe_fwd_b_ctrl}, 32'd0);
      applyStimulus(5'd9, 5'd9, 0, 1, 0, 0, 5'd5, 1, 0, 5'd9, 1, 1);
      checkOutput("unused_fwd_a", {30'd0, hz_bus.exe_fwd_a_ctrl}, 32'd0);
      checkOutput("mem_load_fwd_b", {30'd0, hz_bus.exe_fwd_b_ctrl}, 32'd3);

      // lw $4 in EXE, sw rt=$4 rs=$2: no stall, store data forwarded from WB
      applyStimulus(5'd2, 5'd4, 1, 1, 1, 0, 5'd4, 1, 1, 5'd0, 0, 0);
      checkOutput("store_fwd_m", {31'd0, hz_bus.fwd_m}, 32'd1);
      checkOutput("store_fwd_b", {30'd0, hz_bus.exe_fwd_b_ctrl}, 32'd0);
      checkOutput("store_en_vec", en_vec(), 32'h1f);
      applyStimulus(5'd4, 5'd4, 1, 1, 1, 0, 5'd4, 1, 1, 5'd0, 0, 0);
      checkOutput("store_rs_fwd_m", {31'd0, hz_bus.fwd_m}, 32'd0);
      checkOutput("store_rs_en_vec", en_vec(), 32'h07);
      checkOutput("store_rs_rst_vec", rst_vec(), 32'h04);
      tick();
      applyStimulus(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0);
      checkOutput("store_retry_en_vec", en_vec(), 32'h1f);
      tick();

      // beq: if_en 0,0,1 with id_rst held for all three cycles
      applyStimulus(5'd0, 5'd0, 0, 0, 0, 1, 5'd0, 0, 0, 5'd0, 0, 0);
      checkOutput("br0_en_vec", en_vec(), 32'h0f);
      checkOutput("br0_rst_vec", rst_vec(), 32'h08);
      tick();
      checkOutput("br1_flush_cnt", flush_count, 32'd1);
      checkOutput("br1_en_vec", en_vec(), 32'h0f);
      checkOutput("br1_rst_vec", rst_vec(), 32'h08);
      tick();
      checkOutput("br2_en_vec", en_vec(), 32'h1f);
      checkOutput("br2_rst_vec", rst_vec(), 32'h08);
      tick();
      hz_bus.is_branch_id = 1'b0;
      #1;
      checkOutput("br_done_rst_vec", rst_vec(), 32'h00);
      checkOutput("br_done_flush_cnt", flush_count, 32'd1);
      checkOutput("br_done_stall_cnt", stall_cycles, 32'd4);

      // Second branch, frozen by a 4-cycle memory wait in its second cycle
      hz_bus.is_branch_id = 1'b1;
      #1;
      tick();
      checkOutput("mw_flush_cnt", flush_count, 32'd2);
      hz_bus.mem_req   = 1'b1;
      hz_bus.mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checkOutput($sformatf("mw%0d_en_vec", i), en_vec(), 32'h01);
         checkOutput($sformatf("mw%0d_rst_vec", i), rst_vec(), 32'h01);
         tick();
      end
      checkOutput("mw_stall_cnt", stall_cycles, 32'd9);
      hz_bus.mem_ready = 1'b1;
      #1;
      checkOutput("mw_resume1_en_vec", en_vec(), 32'h0f);
      checkOutput("mw_resume1_rst_vec", rst_vec(), 32'h08);
      tick();
      hz_bus.mem_req = 1'b0;
      #1;
      checkOutput("mw_resume2_en_vec", en_vec(), 32'h1f);
      checkOutput("mw_resume2_rst_vec", rst_vec(), 32'h08);
      tick();
      hz_bus.is_branch_id = 1'b0;
      #1;
      checkOutput("mw_done_rst_vec", rst_vec(), 32'h00);
      checkOutput("mw_done_stall_cnt", stall_cycles, 32'd10);
      checkOutput("mw_done_flush_cnt", flush_count, 32'd2);

      // Asynchronous reset in the middle of a branch sequence
      hz_bus.is_branch_id = 1'b1;
      #1;
      tick();
      checkOutput("abort_pre_flush_cnt", flush_count, 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_rst_vec", rst_vec(), 32'h1f);
      checkOutput("abort_flush_cnt", flush_count, 32'd0);
      checkOutput("abort_stall_cnt", stall_cycles, 32'd0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
